// File: rtl/mem_bus_latency_slave.sv
// Slave-side responder for the XBAR_L2 memory bus: byte-enabled word memory whose
// responses come back in order a fixed LATENCY cycles after acceptance.
module mem_bus_latency_slave #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    data_req_i,
   input  logic [ADDR_WIDTH-1:0]   data_add_i,
   input  logic                    data_wen_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [ID_WIDTH-1:0]     data_ID_i,
   output logic                    data_gnt_o,
   output logic                    data_r_valid_o,
   output logic [DATA_WIDTH-1:0]   data_r_rdata_o,
   output logic [ID_WIDTH-1:0]     data_r_ID_o,
   output logic                    busy_o
);

   localparam int         BE_WIDTH = DATA_WIDTH / 8;
   localparam int         PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int         CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam bit         BYPASS   = (LATENCY == 1);
   localparam logic [3:0] LAT4     = 4'(LATENCY);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] mem_rd;
   logic [DATA_WIDTH-1:0] store_word;
   logic [DATA_WIDTH-1:0] push_data;

   logic [DATA_WIDTH-1:0] fifo_data  [FIFO_DEPTH];
   logic [ID_WIDTH-1:0]   fifo_id    [FIFO_DEPTH];
   logic [3:0]            fifo_stamp [FIFO_DEPTH];

   logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]      count_reg, count_next;
   logic [3:0]            cnt_reg, cnt_next;
   logic                  r_valid_reg, r_valid_next;
   logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
   logic [ID_WIDTH-1:0]   id_reg, id_next;

   logic full, head_due, accept, push, pop, bypass;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Load data is taken from the array at the accepting edge, before any store lands.
   assign mem_rd    = mem[data_add_i];
   assign push_data = data_wen_i ? '0 : mem_rd;

   for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
      assign store_word[gi*8 +: 8] = data_be_i[gi] ? data_wdata_i[gi*8 +: 8] : mem_rd[gi*8 +: 8];
   end

   // The head is emitted on the edge that moves the counter onto its stamp.
   assign cnt_next   = cnt_reg + 4'd1;
   assign full       = (count_reg == CNT_W'(FIFO_DEPTH));
   assign head_due   = (count_reg != '0) && (fifo_stamp[rd_ptr_reg] == cnt_next);
   assign data_gnt_o = !full || head_due;
   assign accept     = data_req_i && data_gnt_o;
   assign bypass     = BYPASS && accept;
   assign push       = accept && !BYPASS;
   assign pop        = head_due;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (push && !pop)
         count_next = count_reg + CNT_W'(1);
      else if (pop && !push)
         count_next = count_reg - CNT_W'(1);
   end

   // With a one-cycle latency the accepted request goes straight to the output registers.
   always_comb begin
      r_valid_next = 1'b0;
      rdata_next   = rdata_reg;
      id_next      = id_reg;
      if (pop) begin
         r_valid_next = 1'b1;
         rdata_next   = fifo_data[rd_ptr_reg];
         id_next      = fifo_id[rd_ptr_reg];
      end else if (bypass) begin
         r_valid_next = 1'b1;
         rdata_next   = push_data;
         id_next      = data_ID_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         cnt_reg     <= '0;
         r_valid_reg <= 1'b0;
         rdata_reg   <= '0;
         id_reg      <= '0;
      end else begin
         wr_ptr_reg  <= wr_ptr_next;
         rd_ptr_reg  <= rd_ptr_next;
         count_reg   <= count_next;
         cnt_reg     <= cnt_next;
         r_valid_reg <= r_valid_next;
         rdata_reg   <= rdata_next;
         id_reg      <= id_next;
      end
   end

   // Storage arrays carry no reset; stale entries are masked by count_reg.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr_reg]  <= push_data;
         fifo_id[wr_ptr_reg]    <= data_ID_i;
         fifo_stamp[wr_ptr_reg] <= cnt_reg + LAT4;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && data_wen_i)
         mem[data_add_i] <= store_word;
   end

   assign data_r_valid_o = r_valid_reg;
   assign data_r_rdata_o = rdata_reg;
   assign data_r_ID_o    = id_reg;
   assign busy_o         = (count_reg != '0);

endmodule

// File: tb/tb_mem_bus_latency_slave.sv
// Bench for mem_bus_latency_slave: four instances with different latency/depth, each driven
// in turn and checked cycle by cycle against a due-time queue model.
module tb_mem_bus_latency_slave;

   localparam int NI = 4;
   localparam int LAT_A [NI] = '{2, 4, 15, 1};
   localparam int DEP_A [NI] = '{4, 2, 8, 1};

   logic        clk;
   logic        rst   [NI];
   logic        req   [NI];
   logic [11:0] add   [NI];
   logic        wen   [NI];
   logic [31:0] wdata [NI];
   logic [3:0]  be    [NI];
   logic [3:0]  id    [NI];
   logic        gnt   [NI];
   logic        rv    [NI];
   logic [31:0] rdata [NI];
   logic [3:0]  rid   [NI];
   logic        busy  [NI];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      mem_bus_latency_slave #(
         .ID_WIDTH(4), .ADDR_WIDTH(12), .DATA_WIDTH(32),
         .LATENCY(LAT_A[gi]), .FIFO_DEPTH(DEP_A[gi])
      ) dut (
         .clk(clk), .rst(rst[gi]),
         .data_req_i(req[gi]), .data_add_i(add[gi]), .data_wen_i(wen[gi]),
         .data_wdata_i(wdata[gi]), .data_be_i(be[gi]), .data_ID_i(id[gi]),
         .data_gnt_o(gnt[gi]), .data_r_valid_o(rv[gi]), .data_r_rdata_o(rdata[gi]),
         .data_r_ID_o(rid[gi]), .busy_o(busy[gi])
      );
   end

   // Reference model: each accepted request becomes a response due at a known edge number.
   typedef struct packed {
      int          due;
      logic [31:0] data;
      logic [3:0]  id;
   } rsp_t;

   rsp_t        q [NI][$];
   logic [31:0] mmem [NI][4096];
   logic [31:0] last_rdata [NI];
   logic [3:0]  last_id [NI];
   int          edge_n;
   int          n_tests;
   int          n_fail;

   task automatic chk(input int u, input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL u%0d %s @edge %0d: observed %h expected %h", u, tag, edge_n, obs, exp);
      end
   endtask

   task automatic tick(input int u, output bit acc);
      bit   exp_gnt, exp_v;
      rsp_t e;
      @(negedge clk);
      exp_gnt = (q[u].size() < DEP_A[u]) || (q[u].size() > 0 && q[u][0].due == edge_n);
      chk(u, "gnt", gnt[u], exp_gnt);
      acc = req[u] && exp_gnt && !rst[u];
      @(posedge clk);
      if (acc) begin
         e.due  = edge_n + LAT_A[u] - 1;
         e.id   = id[u];
         e.data = wen[u] ? 32'h0 : mmem[u][add[u]];
         if (wen[u])
            for (int b = 0; b < 4; b++)
               if (be[u][b]) mmem[u][add[u]][b*8 +: 8] = wdata[u][b*8 +: 8];
         q[u].push_back(e);
      end
      #1;
      exp_v = 1'b0;
      if (q[u].size() > 0 && q[u][0].due == edge_n) begin
         e = q[u].pop_front();
         exp_v = 1'b1;
         last_rdata[u] = e.data;
         last_id[u]    = e.id;
      end
      chk(u, "r_valid", rv[u], exp_v);
      chk(u, "r_rdata", rdata[u], last_rdata[u]);
      chk(u, "r_ID", rid[u], last_id[u]);
      chk(u, "busy", busy[u], q[u].size() != 0);
      if (exp_v)
         $display("[TB] u%0d edge %0d response id=%0d rdata=%h", u, edge_n, rid[u], rdata[u]);
      edge_n++;
   endtask

   task automatic xfer(input int u, input bit w, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [3:0] i);
      bit acc;
      int n;
      req[u] = 1'b1; wen[u] = w; add[u] = a; wdata[u] = d; be[u] = b; id[u] = i;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 40) begin
         tick(u, acc);
         n++;
      end
      if (!acc) begin
         n_tests++;
         n_fail++;
         $error("FAIL u%0d accept_timeout: observed no accept expected accept within 40 cycles", u);
      end
      req[u] = 1'b0;
   endtask

   task automatic idle(input int u, input int n);
      bit acc;
      req[u] = 1'b0;
      for (int k = 0; k < n; k++) tick(u, acc);
   endtask

   task automatic drain(input int u);
      bit acc;
      int n;
      req[u] = 1'b0;
      n = 0;
      while (q[u].size() > 0 && n < 40) begin
         tick(u, acc);
         n++;
      end
      idle(u, 2);
   endtask

   task automatic preload(input int u);
      for (int a = 0; a < 16; a++) xfer(u, 1'b1, 12'(a), $urandom, 4'hf, 4'h0);
      drain(u);
   endtask

   task automatic random_ops(input int u, input int n);
      for (int k = 0; k < n; k++) begin
         xfer(u, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 2) == 0) idle(u, 1);
      end
      drain(u);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      edge_n  = 0;
      for (int u = 0; u < NI; u++) begin
         rst[u] = 1'b1; req[u] = 1'b0; wen[u] = 1'b0; add[u] = '0;
         wdata[u] = '0; be[u] = '0; id[u] = '0;
         last_rdata[u] = '0; last_id[u] = '0;
      end
      @(posedge clk);
      #1;
      for (int u = 0; u < NI; u++) begin
         chk(u, "reset_r_valid", rv[u], 0);
         chk(u, "reset_r_rdata", rdata[u], 0);
         chk(u, "reset_r_ID", rid[u], 0);
         chk(u, "reset_busy", busy[u], 0);
         chk(u, "reset_gnt", gnt[u], 1);
         rst[u] = 1'b0;
      end

      // LATENCY 2, depth 4: basic store/load, byte enables, streaming loads
      preload(0);
      xfer(0, 1'b1, 12'h0fe, 32'hdea0bee0, 4'hf, 4'h0);
      xfer(0, 1'b0, 12'h0fe, 32'h0, 4'h0, 4'h0);
      drain(0);
      xfer(0, 1'b1, 12'h010, 32'hffffffff, 4'hf, 4'h1);
      xfer(0, 1'b1, 12'h010, 32'h00000000, 4'b0101, 4'h2);
      xfer(0, 1'b1, 12'h010, 32'h12345678, 4'b0000, 4'h3);
      xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 4'h4);
      drain(0);
      for (int k = 0; k < 16; k++) xfer(0, 1'b0, 12'($urandom_range(0, 15)), 32'h0, 4'h0, 4'(k));
      drain(0);
      random_ops(0, 40);

      // LATENCY 4, depth 2: back-pressure from a full buffer
      preload(1);
      for (int k = 0; k < 6; k++) xfer(1, 1'b0, 12'(k), 32'h0, 4'h0, 4'(k));
      drain(1);
      random_ops(1, 25);

      // LATENCY 15, depth 8: stamp counter wrap, then reset with responses in flight
      preload(2);
      for (int k = 0; k < 8; k++) begin
         xfer(2, 1'b0, 12'(k), 32'h0, 4'h0, 4'(k + 1));
         idle(2, 2);
      end
      drain(2);
      xfer(2, 1'b1, 12'h005, 32'hcafef00d, 4'hf, 4'h9);
      xfer(2, 1'b0, 12'h005, 32'h0, 4'h0, 4'h1);
      xfer(2, 1'b0, 12'h006, 32'h0, 4'h0, 4'h2);
      xfer(2, 1'b0, 12'h007, 32'h0, 4'h0, 4'h3);
      rst[2] = 1'b1;
      #1;
      chk(2, "async_rst_r_valid", rv[2], 0);
      chk(2, "async_rst_busy", busy[2], 0);
      chk(2, "async_rst_r_rdata", rdata[2], 0);
      chk(2, "async_rst_r_ID", rid[2], 0);
      q[2].delete();
      last_rdata[2] = '0;
      last_id[2]    = '0;
      idle(2, 1);
      rst[2] = 1'b0;
      idle(2, 16);
      xfer(2, 1'b0, 12'h005, 32'h0, 4'h0, 4'h7);
      drain(2);

      // LATENCY 1, depth 1: next-cycle response path
      preload(3);
      xfer(3, 1'b1, 12'h003, 32'h0badc0de, 4'hf, 4'h5);
      xfer(3, 1'b0, 12'h003, 32'h0, 4'h0, 4'h6);
      drain(3);
      random_ops(3, 30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
